// File: rtl/core_types_pkg.sv
// Shared core types: physical register tags and completion-bus sizing used by
// the execute-to-dispatch completion path.
package core_types_pkg;

    localparam int PHYS_REG_TAG_W = 6;
    typedef logic [PHYS_REG_TAG_W-1:0] phys_reg_tag_t;

    localparam int NUM_COMPLETE_SRCS   = 4;
    localparam int NUM_COMPLETE_BUSES  = 3;
    localparam int COMPLETE_FIFO_DEPTH = 2;

    typedef logic [$clog2(NUM_COMPLETE_SRCS)-1:0] complete_src_id_t;

    typedef struct packed {
        phys_reg_tag_t dest_phys_reg_tag;
    } complete_req_t;

endpackage

// File: rtl/complete_req_fifo.sv
// Per-source completion FIFO: holds dest phys reg tags until the arbiter pops
// them; flush empties it and drops any push in the same cycle.
module complete_req_fifo
    import core_types_pkg::*;
#(
    parameter int DEPTH = COMPLETE_FIFO_DEPTH
)
(
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush,
    input  logic                      push,
    input  logic                      pop,
    input  logic [PHYS_REG_TAG_W-1:0] push_tag,
    output logic [PHYS_REG_TAG_W-1:0] head_tag,
    output logic                      full,
    output logic                      empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    complete_req_t    mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage carries no reset; entries are only read while count says valid.
    always_ff @(posedge CLK) begin
        if (!RST && !flush && push) begin
            mem[wr_ptr].dest_phys_reg_tag <= push_tag;
        end
    end

    assign head_tag = mem[rd_ptr].dest_phys_reg_tag;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/complete_bus_arbiter.sv
// Round-robin arbiter sharing the complete buses among buffered completion
// sources. Optional protocol checker enabled by COMPLETE_ARB_CHECK_EN.
module complete_bus_arbiter
    import core_types_pkg::*;
#(
    parameter int NUM_REQ    = NUM_COMPLETE_SRCS,
    parameter int NUM_BUS    = NUM_COMPLETE_BUSES,
    parameter int FIFO_DEPTH = COMPLETE_FIFO_DEPTH
)
(
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      flush,
    input  logic [NUM_REQ-1:0]                        req_valid,
    input  logic [NUM_REQ-1:0][PHYS_REG_TAG_W-1:0]    req_phys_reg_tag,
    output logic [NUM_REQ-1:0]                        req_ready,
    output logic [NUM_BUS-1:0]                        complete_bus_valid,
    output logic [NUM_BUS-1:0][PHYS_REG_TAG_W-1:0]    complete_bus_dest_phys_reg_tag,
    output logic [NUM_BUS-1:0][$clog2(NUM_REQ)-1:0]   complete_bus_src_id,
    output logic                                      DUT_error
);

    localparam int SRC_W = $clog2(NUM_REQ);
    localparam int GCNT_W = $clog2(NUM_BUS + 1);

    logic [NUM_REQ-1:0]        full;
    logic [NUM_REQ-1:0]        empty;
    logic [NUM_REQ-1:0]        push;
    logic [NUM_REQ-1:0]        pop;
    logic [PHYS_REG_TAG_W-1:0] head_tag [NUM_REQ];

    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  last_src;
    logic [SRC_W-1:0]  idx;
    logic [SRC_W:0]    scan;
    logic [GCNT_W-1:0] gcnt;
    logic              any_grant;

    // Ready comes from registered FIFO counts only, so a pop never lends credit
    // to a push in the same cycle.
    assign req_ready = ~full;
    assign push      = req_valid & req_ready & {NUM_REQ{~flush}};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        complete_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
            .CLK      (CLK),
            .RST      (RST),
            .flush    (flush),
            .push     (push[g]),
            .pop      (pop[g]),
            .push_tag (req_phys_reg_tag[g]),
            .head_tag (head_tag[g]),
            .full     (full[g]),
            .empty    (empty[g])
        );
    end

    // Scan from rr_ptr; the k-th non-empty source found drives bus k.
    always_comb begin
        pop                            = '0;
        complete_bus_valid             = '0;
        complete_bus_dest_phys_reg_tag = '0;
        complete_bus_src_id            = '0;
        gcnt                           = '0;
        last_src                       = rr_ptr;
        any_grant                      = 1'b0;
        scan                           = '0;
        idx                            = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (SRC_W+1)'(k);
            if (scan >= (SRC_W+1)'(NUM_REQ)) scan = scan - (SRC_W+1)'(NUM_REQ);
            idx = scan[SRC_W-1:0];
            if (!flush && !empty[idx] && (gcnt < GCNT_W'(NUM_BUS))) begin
                pop[idx] = 1'b1;
                for (int b = 0; b < NUM_BUS; b++) begin
                    if (gcnt == GCNT_W'(b)) begin
                        complete_bus_valid[b]             = 1'b1;
                        complete_bus_dest_phys_reg_tag[b] = head_tag[idx];
                        complete_bus_src_id[b]            = idx;
                    end
                end
                gcnt      = gcnt + GCNT_W'(1);
                last_src  = idx;
                any_grant = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (last_src == SRC_W'(NUM_REQ - 1)) ? '0 : last_src + SRC_W'(1);
        end
    end

`ifdef COMPLETE_ARB_CHECK_EN
    logic [NUM_REQ-1:0] stall_q;
    logic               err_zero_tag;
    logic               err_dup_tag;
    logic               err_drop;

    always_comb begin
        err_zero_tag = 1'b0;
        err_dup_tag  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i] && (req_phys_reg_tag[i] == '0)) err_zero_tag = 1'b1;
        end
        for (int a = 0; a < NUM_BUS; a++) begin
            for (int b = a + 1; b < NUM_BUS; b++) begin
                if (complete_bus_valid[a] && complete_bus_valid[b] &&
                    (complete_bus_dest_phys_reg_tag[a] == complete_bus_dest_phys_reg_tag[b]))
                    err_dup_tag = 1'b1;
            end
        end
        err_drop = |(stall_q & ~req_valid);
    end

    // A stalled source (valid without ready) must keep presenting next cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            DUT_error <= 1'b0;
            stall_q   <= '0;
        end else begin
            DUT_error <= err_zero_tag | err_dup_tag | err_drop;
            stall_q   <= req_valid & ~req_ready;
            if (err_zero_tag) $display("complete_bus_arbiter: push with zero dest tag");
            if (err_dup_tag)  $display("complete_bus_arbiter: duplicate tag on complete buses");
            if (err_drop)     $display("complete_bus_arbiter: req_valid dropped while stalled");
        end
    end
`else
    assign DUT_error = 1'b0;
`endif

endmodule

// File: tb/tb_complete_bus_arbiter.sv
// Directed bench for complete_bus_arbiter: reset, single completion,
// contention, backpressure, flush and tag-zero push.
module tb_complete_bus_arbiter;
    import core_types_pkg::*;

    logic                                   CLK = 1'b0;
    logic                                   RST;
    logic                                   flush;
    logic [3:0]                             req_valid;
    logic [3:0][PHYS_REG_TAG_W-1:0]         req_phys_reg_tag;
    logic [3:0]                             req_ready;
    logic [2:0]                             complete_bus_valid;
    logic [2:0][PHYS_REG_TAG_W-1:0]         complete_bus_dest_phys_reg_tag;
    logic [2:0][1:0]                        complete_bus_src_id;
    logic                                   DUT_error;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    complete_bus_arbiter dut (
        .CLK                            (CLK),
        .RST                            (RST),
        .flush                          (flush),
        .req_valid                      (req_valid),
        .req_phys_reg_tag               (req_phys_reg_tag),
        .req_ready                      (req_ready),
        .complete_bus_valid             (complete_bus_valid),
        .complete_bus_dest_phys_reg_tag (complete_bus_dest_phys_reg_tag),
        .complete_bus_src_id            (complete_bus_src_id),
        .DUT_error                      (DUT_error)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input int b, input logic [5:0] t, input logic [1:0] s);
        chk($sformatf("%s bus%0d tag", tag, b), 32'(complete_bus_dest_phys_reg_tag[b]), 32'(t));
        chk($sformatf("%s bus%0d src", tag, b), 32'(complete_bus_src_id[b]), 32'(s));
    endtask

    task automatic set_tags(input logic [5:0] t0, input logic [5:0] t1,
                            input logic [5:0] t2, input logic [5:0] t3);
        req_phys_reg_tag[0] = t0;
        req_phys_reg_tag[1] = t1;
        req_phys_reg_tag[2] = t2;
        req_phys_reg_tag[3] = t3;
    endtask

    initial begin
        RST       = 1'b1;
        flush     = 1'b0;
        req_valid = '0;
        set_tags(0, 0, 0, 0);

        // Reset
        tick();
        tick();
        RST = 1'b0;
        chk("rst ready", 32'(req_ready), 32'hf);
        chk("rst valid", 32'(complete_bus_valid), 32'h0);
        chk("rst error", 32'(DUT_error), 32'h0);

        // Single completion from ALU0
        req_valid = 4'b0001;
        set_tags(7, 0, 0, 0);
        tick();
        req_valid = '0;
        chk("single valid", 32'(complete_bus_valid), 32'h1);
        chk_bus("single", 0, 6'd7, 2'd0);
        chk_bus("single", 1, 6'd0, 2'd0);
        chk_bus("single", 2, 6'd0, 2'd0);
        tick();
        chk("single drained", 32'(complete_bus_valid), 32'h0);

        // Contention from rr_ptr = 0
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req_valid = 4'b1111;
        set_tags(10, 11, 12, 13);
        tick();
        req_valid = '0;
        chk("cont c1 valid", 32'(complete_bus_valid), 32'h7);
        chk_bus("cont c1", 0, 6'd10, 2'd0);
        chk_bus("cont c1", 1, 6'd11, 2'd1);
        chk_bus("cont c1", 2, 6'd12, 2'd2);
        tick();
        chk("cont c2 valid", 32'(complete_bus_valid), 32'h1);
        chk_bus("cont c2", 0, 6'd13, 2'd3);
        tick();
        chk("cont c3 valid", 32'(complete_bus_valid), 32'h0);

        // Prelude: grant sources 0,1,2 so rr_ptr moves to 3
        req_valid = 4'b0111;
        set_tags(1, 2, 3, 0);
        tick();
        req_valid = '0;
        chk("pre valid", 32'(complete_bus_valid), 32'h7);
        tick();
        chk("pre drained", 32'(complete_bus_valid), 32'h0);

        // Backpressure on LQ while the other sources keep the buses busy
        req_valid = 4'b1111;
        set_tags(40, 48, 20, 56);
        tick();
        chk("bp c0 ready", 32'(req_ready), 32'hf);
        chk_bus("bp c0", 0, 6'd56, 2'd3);
        chk_bus("bp c0", 1, 6'd40, 2'd0);
        chk_bus("bp c0", 2, 6'd48, 2'd1);
        set_tags(41, 49, 21, 57);
        tick();
        chk("bp c1 ready", 32'(req_ready), 32'hb);
        chk_bus("bp c1", 0, 6'd20, 2'd2);
        chk_bus("bp c1", 1, 6'd57, 2'd3);
        chk_bus("bp c1", 2, 6'd41, 2'd0);
        set_tags(42, 50, 22, 58);
        tick();
        chk("bp c2 ready", 32'(req_ready), 32'hd);
        chk_bus("bp c2", 0, 6'd49, 2'd1);
        chk_bus("bp c2", 1, 6'd21, 2'd2);
        chk_bus("bp c2", 2, 6'd58, 2'd3);
        set_tags(43, 51, 22, 59);
        tick();
        chk("bp c3 ready", 32'(req_ready), 32'he);
        chk_bus("bp c3", 0, 6'd42, 2'd0);
        chk_bus("bp c3", 1, 6'd50, 2'd1);
        chk_bus("bp c3", 2, 6'd22, 2'd2);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        chk("bp c4 valid", 32'(complete_bus_valid), 32'h7);
        chk_bus("bp c4", 0, 6'd59, 2'd3);
        chk_bus("bp c4", 1, 6'd43, 2'd0);
        chk_bus("bp c4", 2, 6'd51, 2'd1);
        tick();
        chk("bp c5 valid", 32'(complete_bus_valid), 32'h0);
        chk("bp c5 ready", 32'(req_ready), 32'hf);

        // Flush with three entries buffered and a concurrent push of tag 30
        req_valid = 4'b1011;
        set_tags(25, 26, 0, 27);
        tick();
        req_valid = 4'b0100;
        set_tags(0, 0, 30, 0);
        flush = 1'b1;
        #1;
        chk("flush valid", 32'(complete_bus_valid), 32'h0);
        tick();
        flush     = 1'b0;
        req_valid = '0;
        chk("post flush ready", 32'(req_ready), 32'hf);
        chk("post flush valid", 32'(complete_bus_valid), 32'h0);
        tick();
        chk("post flush valid2", 32'(complete_bus_valid), 32'h0);

        // rr_ptr held at 2 across the flush
        req_valid = 4'b1111;
        set_tags(33, 34, 35, 36);
        tick();
        req_valid = '0;
        chk("rr hold valid", 32'(complete_bus_valid), 32'h7);
        chk_bus("rr hold", 0, 6'd35, 2'd2);
        chk_bus("rr hold", 1, 6'd36, 2'd3);
        chk_bus("rr hold", 2, 6'd33, 2'd0);
        tick();
        chk("rr hold c2 valid", 32'(complete_bus_valid), 32'h1);
        chk_bus("rr hold c2", 0, 6'd34, 2'd1);
        tick();
        chk("rr hold c3 valid", 32'(complete_bus_valid), 32'h0);

        // ALU1 pushes tag 0
        req_valid = 4'b0010;
        set_tags(0, 0, 0, 0);
        tick();
        req_valid = '0;
        chk("tag0 valid", 32'(complete_bus_valid), 32'h1);
        chk_bus("tag0", 0, 6'd0, 2'd1);
`ifdef COMPLETE_ARB_CHECK_EN
        chk("tag0 error set", 32'(DUT_error), 32'h1);
`else
        chk("tag0 error tied", 32'(DUT_error), 32'h0);
`endif
        tick();
        chk("tag0 error clear", 32'(DUT_error), 32'h0);
        chk("tag0 drained", 32'(complete_bus_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
